// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master feeder: FSM state encoding and the
// default word width, bit-index width, FIFO geometry and accept timeout.
// Pure declarations; no logic or state.
package spi_pkg;

  localparam int SPI_DATA_W        = 32; // SPI word width
  localparam int SPI_IDX_W         = 5;  // log2(SPI_DATA_W)
  localparam int SPI_FIFO_DEPTH    = 8;
  localparam int SPI_FIFO_AW       = 3;  // log2(SPI_FIFO_DEPTH)
  localparam int SPI_START_TIMEOUT = 16; // cycles allowed for spi_master to accept a word

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_CAPTURE    = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for the feeder TX and RX queues.
// Latency: a word pushed in cycle N is visible at op_rd_data / !o_empty in cycle N+1.
// Backpressure: pushes while full and pops while empty are ignored; caller watches o_full/o_empty.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset (clears pointers)
//   ip_wr_data, i_wr_en    push side
//   op_rd_data, i_rd_en    pop side, op_rd_data shows the head whenever !o_empty
//   o_full, o_empty        occupancy flags, from pointers carrying one extra wrap bit
module spi_sync_fifo import spi_pkg::*; #(
  parameter int p_width = SPI_DATA_W,
  parameter int p_depth = SPI_FIFO_DEPTH,
  parameter int pw_addr = SPI_FIFO_AW
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [p_width-1:0] ip_wr_data,
  input  logic               i_wr_en,
  output logic [p_width-1:0] op_rd_data,
  input  logic               i_rd_en,
  output logic               o_full,
  output logic               o_empty
);

  logic [pw_addr:0]   wr_ptr_q, wr_ptr_d;
  logic [pw_addr:0]   rd_ptr_q, rd_ptr_d;
  logic [p_width-1:0] mem_q [p_depth];
  logic [p_width-1:0] mem_d [p_depth];
  logic               push_ok;
  logic               pop_ok;

  // Same low bits with differing wrap bit means the writer is a full lap ahead.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[pw_addr] != rd_ptr_q[pw_addr]) &&
                   (wr_ptr_q[pw_addr-1:0] == rd_ptr_q[pw_addr-1:0]);

  assign push_ok    = i_wr_en && !o_full;
  assign pop_ok     = i_rd_en && !o_empty;
  assign op_rd_data = mem_q[rd_ptr_q[pw_addr-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[pw_addr-1:0]] = ip_wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_master_feeder.sv
// Sequences host words into spi_master and queues every received word for the host.
// Latency: word written in cycle N drives o_data_valid in cycle N+2 at the earliest.
// Backpressure: o_wr_ready drops when the TX FIFO is full; a full RX FIFO holds the FSM in CAPTURE.
//
// Ports:
//   clk, resetn                              clock, synchronous active-low reset
//   ip_wr_data, ip_wr_count, i_wr_valid,
//   o_wr_ready                               host TX write port
//   op_data, op_data_count, o_data_valid,
//   i_data_ready, ip_rd_data                 spi_master word handshake and received data
//   op_rd_data, o_rd_valid, i_rd_ready       host RX read port (first-word-fall-through)
//   o_busy                                   FSM active or TX words pending
//   o_error                                  one-cycle pulse for an illegal count or accept timeout
//   op_xfer_count                            completed-transfer counter, present only when
//                                            SPI_FEEDER_STATS_EN is defined
module spi_master_feeder import spi_pkg::*; #(
  parameter int p_max_data_buffer = SPI_DATA_W,
  parameter int pw_data_index     = SPI_IDX_W,
  parameter int p_fifo_depth      = SPI_FIFO_DEPTH,
  parameter int pw_fifo_addr      = SPI_FIFO_AW,
  parameter int p_start_timeout   = SPI_START_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [p_max_data_buffer-1:0] ip_wr_data,
  input  logic [pw_data_index:0]       ip_wr_count,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  output logic [p_max_data_buffer-1:0] op_data,
  output logic [pw_data_index:0]       op_data_count,
  output logic                         o_data_valid,
  input  logic                         i_data_ready,
  input  logic [p_max_data_buffer-1:0] ip_rd_data,
  output logic [p_max_data_buffer-1:0] op_rd_data,
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic                         o_busy,
  output logic                         o_error
`ifdef SPI_FEEDER_STATS_EN
  ,
  output logic [15:0]                  op_xfer_count
`endif
);

  localparam int TX_W = p_max_data_buffer + pw_data_index + 1;
  localparam int TO_W = $clog2(p_start_timeout + 1);
  localparam logic [pw_data_index:0] LP_MAX_CNT = (pw_data_index + 1)'(p_max_data_buffer);
  localparam logic [TO_W-1:0]        LP_TO_LAST = TO_W'(p_start_timeout - 1);

  feeder_state_e                  state_q, state_d;
  logic [p_max_data_buffer-1:0]   op_data_q, op_data_d;
  logic [pw_data_index:0]         op_cnt_q, op_cnt_d;
  logic                           data_vld_q, data_vld_d;
  logic                           error_q, error_d;
  logic [TO_W-1:0]                timeout_cnt_q, timeout_cnt_d;
  logic                           rst_done_q, rst_done_d;

  logic                           tx_full, tx_empty, tx_pop, tx_push;
  logic [TX_W-1:0]                tx_head;
  logic [p_max_data_buffer-1:0]   tx_head_dat;
  logic [pw_data_index:0]         tx_head_cnt;
  logic                           rx_full, rx_empty, rx_push, rx_pop;
  logic [p_max_data_buffer-1:0]   rx_head;

  // o_wr_ready stays low while reset is held and for the reset edge itself.
  assign o_wr_ready = rst_done_q && !tx_full;
  assign tx_push    = i_wr_valid && o_wr_ready;

  spi_sync_fifo #(
    .p_width (TX_W),
    .p_depth (p_fifo_depth),
    .pw_addr (pw_fifo_addr)
  ) u_tx_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .ip_wr_data ({ip_wr_data, ip_wr_count}),
    .i_wr_en    (tx_push),
    .op_rd_data (tx_head),
    .i_rd_en    (tx_pop),
    .o_full     (tx_full),
    .o_empty    (tx_empty)
  );

  assign tx_head_dat = tx_head[TX_W-1 -: p_max_data_buffer];
  assign tx_head_cnt = tx_head[pw_data_index:0];

  assign rx_pop = i_rd_ready && !rx_empty;

  spi_sync_fifo #(
    .p_width (p_max_data_buffer),
    .p_depth (p_fifo_depth),
    .pw_addr (pw_fifo_addr)
  ) u_rx_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .ip_wr_data (ip_rd_data),
    .i_wr_en    (rx_push),
    .op_rd_data (rx_head),
    .i_rd_en    (rx_pop),
    .o_full     (rx_full),
    .o_empty    (rx_empty)
  );

  // Storage behind an empty FIFO is stale, so the host sees zero then.
  assign o_rd_valid    = !rx_empty;
  assign op_rd_data    = rx_empty ? '0 : rx_head;
  assign op_data       = op_data_q;
  assign op_data_count = op_cnt_q;
  assign o_data_valid  = data_vld_q;
  assign o_error       = error_q;
  assign o_busy        = (state_q != ST_IDLE) || !tx_empty;

  always_comb begin
    state_d       = state_q;
    op_data_d     = op_data_q;
    op_cnt_d      = op_cnt_q;
    data_vld_d    = 1'b0;
    error_d       = 1'b0;
    timeout_cnt_d = timeout_cnt_q;
    rst_done_d    = 1'b1;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && i_data_ready) begin
          tx_pop    = 1'b1;
          op_data_d = tx_head_dat;
          op_cnt_d  = tx_head_cnt;
          if ((tx_head_cnt != '0) && (tx_head_cnt <= LP_MAX_CNT)) begin
            state_d    = ST_LOAD;
            data_vld_d = 1'b1;
          end else begin
            // Illegal bit count: word is consumed but never reaches spi_master.
            error_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d       = ST_WAIT_START;
        timeout_cnt_d = '0;
      end
      ST_WAIT_START: begin
        // spi_master signals acceptance by dropping its ready.
        if (!i_data_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_cnt_q == LP_TO_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (i_data_ready) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!rx_full) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      op_data_q     <= '0;
      op_cnt_q      <= '0;
      data_vld_q    <= 1'b0;
      error_q       <= 1'b0;
      timeout_cnt_q <= '0;
      rst_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_data_q     <= op_data_d;
      op_cnt_q      <= op_cnt_d;
      data_vld_q    <= data_vld_d;
      error_q       <= error_d;
      timeout_cnt_q <= timeout_cnt_d;
      rst_done_q    <= rst_done_d;
    end
  end

`ifdef SPI_FEEDER_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Free-running count of captured words; wraps through zero.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (rx_push) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign op_xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_spi_master_feeder.sv
// Directed bench for spi_master_feeder with a behavioural spi_master responder.
// The responder returns the bitwise inverse of each word it is handed.
module tb_spi_master_feeder;

  localparam int MODE_AUTO = 0;
  localparam int MODE_LOW  = 1;
  localparam int MODE_HIGH = 2;

  logic        clk;
  logic        resetn;
  logic [31:0] ip_wr_data;
  logic [5:0]  ip_wr_count;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [31:0] op_data;
  logic [5:0]  op_data_count;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [31:0] ip_rd_data;
  logic [31:0] op_rd_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic        o_busy;
  logic        o_error;
`ifdef SPI_FEEDER_STATS_EN
  logic [15:0] op_xfer_count;
`endif

  int n_cmp      = 0;
  int n_err      = 0;
  int slave_mode = MODE_HIGH;
  int busy_left  = 0;
  int dv_count   = 0;
  int err_count  = 0;
  logic [31:0] rx_words[$];

  spi_master_feeder dut (
    .clk           (clk),
    .resetn        (resetn),
    .ip_wr_data    (ip_wr_data),
    .ip_wr_count   (ip_wr_count),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .op_data       (op_data),
    .op_data_count (op_data_count),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .ip_rd_data    (ip_rd_data),
    .op_rd_data    (op_rd_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_busy        (o_busy),
    .o_error       (o_error)
`ifdef SPI_FEEDER_STATS_EN
    ,
    .op_xfer_count (op_xfer_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // spi_master stand-in: accepts a word on o_data_valid, stays busy a few cycles.
  initial begin
    i_data_ready = 1'b1;
    ip_rd_data   = '0;
    forever begin
      @(negedge clk);
      if (slave_mode == MODE_LOW) begin
        i_data_ready = 1'b0;
        busy_left    = 0;
      end else if (slave_mode == MODE_HIGH) begin
        i_data_ready = 1'b1;
        busy_left    = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) i_data_ready = 1'b1;
      end else if (!i_data_ready) begin
        i_data_ready = 1'b1;
      end else if (o_data_valid === 1'b1) begin
        i_data_ready = 1'b0;
        busy_left    = 3;
        ip_rd_data   = ~op_data;
      end
    end
  end

  // Cycle counts of o_data_valid and o_error being high.
  initial begin
    forever begin
      @(negedge clk);
      if (o_data_valid === 1'b1) dv_count++;
      if (o_error === 1'b1) err_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [5:0] c);
    logic acc;
    acc         = 1'b0;
    ip_wr_data  = d;
    ip_wr_count = c;
    i_wr_valid  = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      acc = o_wr_ready;
      tick();
    end
    i_wr_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_dv(input int maxc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      if (o_data_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("wait_data_valid", 32'(seen), 32'd1);
  endtask

  task automatic wait_rd(input int maxc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      if (o_rd_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("wait_rd_valid", 32'(seen), 32'd1);
  endtask

  task automatic drain(input int cycles);
    i_rd_ready = 1'b1;
    repeat (cycles) begin
      if (o_rd_valid === 1'b1) rx_words.push_back(op_rd_data);
      tick();
    end
    i_rd_ready = 1'b0;
  endtask

  initial begin
    int dv0;
    int e0;
    int cyc;

    resetn      = 1'b0;
    ip_wr_data  = '0;
    ip_wr_count = '0;
    i_wr_valid  = 1'b0;
    i_rd_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_data_valid", 32'(o_data_valid), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_op_data", op_data, 32'd0);
    chk("rst_op_count", 32'(op_data_count), 32'd0);
    chk("rst_rd_data", op_rd_data, 32'd0);
    resetn = 1'b1;
    tick();
    chk("release_wr_ready", 32'(o_wr_ready), 32'd1);

    // Single word 0xA5, 8 bits: o_data_valid at N+2, one cycle wide
    slave_mode  = MODE_AUTO;
    dv0         = dv_count;
    ip_wr_data  = 32'h0000_00A5;
    ip_wr_count = 6'd8;
    i_wr_valid  = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    chk("single_dv_n1", 32'(o_data_valid), 32'd0);
    chk("single_busy_n1", 32'(o_busy), 32'd1);
    tick();
    chk("single_dv_n2", 32'(o_data_valid), 32'd1);
    chk("single_op_data", op_data, 32'h0000_00A5);
    chk("single_op_count", 32'(op_data_count), 32'd8);
    tick();
    chk("single_dv_n3", 32'(o_data_valid), 32'd0);
    wait_rd(30);
    chk("single_rx_word", op_rd_data, 32'hFFFF_FF5A);
    chk("single_busy_done", 32'(o_busy), 32'd0);
    chk("single_dv_pulses", 32'(dv_count - dv0), 32'd1);
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
    chk("single_rx_popped", 32'(o_rd_valid), 32'd0);

    // TX full: spi_master never ready, 9 writes offered
    slave_mode = MODE_LOW;
    repeat (2) tick();
    for (int i = 0; i < 9; i++) begin
      ip_wr_data  = 32'h0000_1000 + 32'(i);
      ip_wr_count = 6'd16;
      i_wr_valid  = 1'b1;
      chk("txfull_wr_ready", 32'(o_wr_ready), 32'(i < 8));
      tick();
    end
    i_wr_valid = 1'b0;
    chk("txfull_busy", 32'(o_busy), 32'd1);
    slave_mode = MODE_AUTO;
    rx_words.delete();
    drain(150);
    chk("txfull_rx_count", 32'(rx_words.size()), 32'd8);
    for (int i = 0; i < 8 && i < rx_words.size(); i++) begin
      chk("txfull_rx_word", rx_words[i], ~(32'h0000_1000 + 32'(i)));
    end
    chk("txfull_busy_done", 32'(o_busy), 32'd0);
    chk("txfull_wr_ready_back", 32'(o_wr_ready), 32'd1);

    // Illegal counts 0 and 33
    dv0 = dv_count;
    e0  = err_count;
    push_word(32'h0000_0011, 6'd0);
    push_word(32'h0000_0022, 6'd33);
    repeat (10) tick();
    chk("illegal_err_pulses", 32'(err_count - e0), 32'd2);
    chk("illegal_no_dv", 32'(dv_count - dv0), 32'd0);
    chk("illegal_no_rx", 32'(o_rd_valid), 32'd0);
    chk("illegal_busy", 32'(o_busy), 32'd0);

    // Accept timeout: ready held high after LOAD
    slave_mode = MODE_HIGH;
    tick();
    e0 = err_count;
    push_word(32'h0000_0077, 6'd4);
    wait_dv(10);
    cyc = 0;
    while (o_error !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles_from_load", 32'(cyc), 32'd17);
    chk("timeout_busy_idle", 32'(o_busy), 32'd0);
    tick();
    chk("timeout_err_one_cycle", 32'(o_error), 32'd0);
    repeat (3) tick();
    chk("timeout_err_count", 32'(err_count - e0), 32'd1);
    chk("timeout_no_rx", 32'(o_rd_valid), 32'd0);

    // RX backpressure: 10 full-width words with host not reading
    slave_mode = MODE_AUTO;
    i_rd_ready = 1'b0;
    tick();
    dv0 = dv_count;
    for (int i = 0; i < 10; i++) begin
      push_word(32'hC0DE_0000 + 32'(i), 6'd32);
    end
    repeat (100) tick();
    chk("rxbp_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("rxbp_busy_stalled", 32'(o_busy), 32'd1);
    chk("rxbp_dv_stalled", 32'(dv_count - dv0), 32'd9);
    rx_words.delete();
    i_rd_ready = 1'b1;
    rx_words.push_back(op_rd_data);
    tick();
    i_rd_ready = 1'b0;
    repeat (20) tick();
    chk("rxbp_dv_resumed", 32'(dv_count - dv0), 32'd10);
    drain(150);
    chk("rxbp_rx_count", 32'(rx_words.size()), 32'd10);
    for (int i = 0; i < 10 && i < rx_words.size(); i++) begin
      chk("rxbp_rx_word", rx_words[i], ~(32'hC0DE_0000 + 32'(i)));
    end

    // Reset while the FSM waits for transfer completion
    push_word(32'h0000_BEEF, 6'd16);
    wait_rd(30);
    push_word(32'h0000_CAFE, 6'd16);
    wait_dv(10);
    slave_mode = MODE_LOW;
    repeat (3) tick();
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    chk("midrst_rx_before", 32'(o_rd_valid), 32'd1);
    resetn = 1'b0;
    tick();
    chk("midrst_data_valid", 32'(o_data_valid), 32'd0);
    chk("midrst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("midrst_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    resetn     = 1'b1;
    slave_mode = MODE_HIGH;
    tick();
    chk("midrst_release_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("midrst_release_rd_valid", 32'(o_rd_valid), 32'd0);

    // Traffic after reset
    slave_mode = MODE_AUTO;
    tick();
    push_word(32'h0000_003C, 6'd6);
    wait_rd(30);
    chk("post_rst_rx_word", op_rd_data, 32'hFFFF_FFC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_feeder.md
Name: spi_master_feeder

Overview:
- Transaction sequencer that sits directly upstream of spi_master.
- Buffers host words and their bit counts in a TX FIFO, and hands each word to spi_master over its ip_data / ip_data_count / i_data_valid / o_data_ready handshake.
- Captures spi_master's orp_data after every completed transfer into an RX FIFO that the host drains through a valid/ready port.

Parameters:
- p_max_data_buffer, 32, SPI word width; must match spi_master.
- pw_data_index, 5, log2(p_max_data_buffer); bit-count ports are pw_data_index+1 wide.
- p_fifo_depth, 8, TX and RX FIFO depth; power of two, at least 2.
- pw_fifo_addr, 3, log2(p_fifo_depth).
- p_start_timeout, 16, cycles to wait for spi_master to accept a word before aborting.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- ip_wr_data  in  p_max_data_buffer  host word to transmit.
- ip_wr_count  in  pw_data_index+1  bits to transmit for that word.
- i_wr_valid  in  1  host write strobe.
- o_wr_ready  out  1  TX FIFO not full.
- op_data  out  p_max_data_buffer  to spi_master ip_data.
- op_data_count  out  pw_data_index+1  to spi_master ip_data_count.
- o_data_valid  out  1  to spi_master i_data_valid.
- i_data_ready  in  1  from spi_master o_data_ready.
- ip_rd_data  in  p_max_data_buffer  from spi_master orp_data.
- op_rd_data  out  p_max_data_buffer  received word to host.
- o_rd_valid  out  1  RX FIFO not empty.
- i_rd_ready  in  1  host pop.
- o_busy  out  1  FSM not in IDLE, or TX FIFO not empty.
- o_error  out  1  one-cycle pulse on an aborted or illegal word.

Behaviour:
- Reset: all state is updated on the rising clk edge; resetn low clears both FIFOs and forces the FSM to IDLE.
  - Output values during reset: o_data_valid=0, o_error=0, o_busy=0, o_wr_ready=0, o_rd_valid=0.
  - op_data, op_data_count and op_rd_data are all 0.
  - Cycle after release: o_wr_ready=1.
- TX FIFO write: a word is pushed when i_wr_valid && o_wr_ready.
  - o_wr_ready = !tx_full.
  - No same-cycle pass-through: a word pushed in cycle N is visible to the FSM in N+1.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE, CAPTURE.
- IDLE: when !tx_empty && i_data_ready, pop the TX head and register op_data / op_data_count.
  - Head count in 1..p_max_data_buffer: go to LOAD.
  - Head count 0 or above p_max_data_buffer: drop the word, pulse o_error, stay in IDLE; no SPI transfer and no RX word.
- LOAD: o_data_valid=1 for exactly one cycle; go to WAIT_START and clear the timeout counter.
- WAIT_START: wait for i_data_ready=0, then go to WAIT_DONE.
  - If the counter reaches p_start_timeout first: pulse o_error, go to IDLE, no RX word.
- WAIT_DONE: wait for i_data_ready=1, then go to CAPTURE.
- CAPTURE: if RX FIFO not full, push ip_rd_data and go to IDLE.
  - If RX FIFO is full, stay in CAPTURE (backpressure; no data loss, TX stalls).
- Latency: word written in cycle N gives o_data_valid high in cycle N+2 at the earliest.
- op_data and op_data_count hold their value from the IDLE pop until the next pop.
- RX read: first-word-fall-through; op_rd_data is valid whenever o_rd_valid=1; pop on o_rd_valid && i_rd_ready.
- A same-cycle RX push and pop are both honoured when the FIFO is neither full nor empty.
- Both FIFO pointers wrap modulo p_fifo_depth; full/empty are derived from an extra pointer MSB.
- Bit-count arithmetic is unsigned; data bits above the count are passed to spi_master unchanged.
- Reset mid-transfer: the FSM returns to IDLE immediately; the in-flight RX word is discarded. spi_master shares the reset, so there is no stale completion.

Optional Feature:
- Macro: SPI_FEEDER_STATS_EN.
- Defined: adds output op_xfer_count [15:0].
  - Increments on every CAPTURE push and wraps at 0xFFFF→0.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package spi_pkg:
  - FSM state encoding (3-bit).
  - Default word width and index width constants.
  - Default timeout value.
- Sub-module spi_sync_fifo, parameterised by width and depth, FWFT, with full/empty outputs.
  - Instantiated twice: TX with width p_max_data_buffer+pw_data_index+1, RX with width p_max_data_buffer.

Test Plan:
- Single word: write 0xA5 count 8, spi_master looped to spi_slave → o_data_valid pulses once at cycle N+2; the RX word appears with o_rd_valid=1; o_busy falls afterwards.
- TX full: write 9 words with no transfers possible (i_data_ready held 0) → o_wr_ready=0 after the 8th; the 9th is not accepted; draining delivers all 8 in order.
- Illegal count: write count 0 and then count 33 (with p_max_data_buffer=32) → two o_error pulses, no o_data_valid, no RX words.
- Timeout: hold i_data_ready=1 after LOAD → o_error pulse exactly 16 cycles after WAIT_START entry; FSM back in IDLE.
- RX backpressure: i_rd_ready=0, send 10 words → 8 RX words stored, FSM stuck in CAPTURE on the 9th; after one pop, transfers resume and all 10 words are received in order.
- Reset mid-transfer: assert resetn=0 during WAIT_DONE → next cycle o_data_valid=0, o_rd_valid=0, o_wr_ready=0; o_wr_ready=1 on the cycle after release.
